// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
// Groups the signals between the divide sequencer, the EXE stage, the result
// consumer and the multi-cycle divider.
//   Request  : req_valid, req_op, req_a, req_b  -> sequencer; req_ready back
//   Flush    : flush                            -> sequencer
//   Response : resp_valid, resp_data            -> consumer; resp_ready back
//   Divider  : div_start, div_op, div_a, div_b  -> divider;  div_f, div_done back
//   Status   : err_timeout (sticky watchdog flag)
// Modports:
//   slave  - the sequencer itself
//   master - everything around it (EXE, consumer, divider)
// -----------------------------------------------------------------------------
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            req_ready;
    logic            flush;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            resp_ready;
    logic            div_start;
    logic [1:0]      div_op;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic [XLEN-1:0] div_f;
    logic            div_done;
    logic            err_timeout;

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, resp_ready, div_f, div_done,
        output req_ready, resp_valid, resp_data, div_start, div_op, div_a, div_b,
               err_timeout
    );

    modport master (
        output req_valid, req_op, req_a, req_b, flush, resp_ready, div_f, div_done,
        input  req_ready, resp_valid, resp_data, div_start, div_op, div_a, div_b,
               err_timeout
    );
endinterface

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Sequences the multi-cycle EXE-stage divider for DIV/DIVU/REM/REMU.
// Accepts one request at a time, holds the operands for the divider, pulses
// div_start, waits for div_done and returns the result over valid/ready.
// Divide-by-zero and signed overflow are answered directly (no divider use).
// Flushes are absorbed: since the divider cannot abort, an in-flight divider
// op is drained (result discarded) before a new request is accepted.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        div_sequencer_if.slave (request, response, divider, status)
// Parameters:
//   XLEN       operand/result width
//   WDOG_CYC   divider cycles (counted from START) before err_timeout is set
// Optional feature (macro DIV_SEQ_PAIR_CACHE_EN):
//   Keeps {a,b,signedness} plus quotient and remainder of the last divider op;
//   the missing half is filled in idle background cycles. A matching request
//   is answered in one cycle. Undefined: every non-special op uses the divider.
// -----------------------------------------------------------------------------
module div_sequencer #(
    parameter int XLEN     = 32,
    parameter int WDOG_CYC = 40
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(WDOG_CYC + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_START, S_BUSY, S_DRAIN, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [CW-1:0]   wdog_q, wdog_d;
    logic            err_q, err_d;

    logic            accept, b_zero, ovf, wdog_hit;
    logic [XLEN-1:0] special_val;

    // op[1] selects remainder, op[0] selects unsigned
    assign accept      = bus.req_valid && bus.req_ready;
    assign b_zero      = (bus.req_b == '0);
    assign ovf         = !bus.req_op[0] && (bus.req_a == INT_MIN) && (bus.req_b == '1);
    assign special_val = b_zero ? (bus.req_op[1] ? bus.req_a : '1)
                                : (bus.req_op[1] ? '0 : INT_MIN);
    assign wdog_hit    = (wdog_q >= CW'(WDOG_CYC - 1));

`ifdef DIV_SEQ_PAIR_CACHE_EN
    logic            c_vld_q, c_vld_d, c_sgn_q, c_sgn_d;
    logic            c_qv_q, c_qv_d, c_rv_q, c_rv_d, fill_q, fill_d;
    logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
    logic            c_hit, fill_go;

    assign c_hit   = c_vld_q && (c_sgn_q == !bus.req_op[0]) &&
                     (c_a_q == bus.req_a) && (c_b_q == bus.req_b) &&
                     (bus.req_op[1] ? c_rv_q : c_qv_q);
    // Background fill only when exactly one half of the pair is missing
    assign fill_go = c_vld_q && (c_qv_q != c_rv_q) && !bus.req_valid && !bus.flush;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
`ifdef DIV_SEQ_PAIR_CACHE_EN
        c_vld_d = c_vld_q;
        c_sgn_d = c_sgn_q;
        c_qv_d  = c_qv_q;
        c_rv_d  = c_rv_q;
        c_a_d   = c_a_q;
        c_b_d   = c_b_q;
        c_quo_d = c_quo_q;
        c_rem_d = c_rem_q;
        fill_d  = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = bus.req_op;
                    a_d    = bus.req_a;
                    b_d    = bus.req_b;
                    wdog_d = '0;
`ifdef DIV_SEQ_PAIR_CACHE_EN
                    fill_d = 1'b0;
`endif
                    if (b_zero || ovf) begin
                        data_d  = special_val;
                        state_d = S_RESP;
                    end
`ifdef DIV_SEQ_PAIR_CACHE_EN
                    else if (c_hit) begin
                        data_d  = bus.req_op[1] ? c_rem_q : c_quo_q;
                        state_d = S_RESP;
                    end
`endif
                    else begin
                        state_d = S_START;
                    end
                end
`ifdef DIV_SEQ_PAIR_CACHE_EN
                else if (fill_go) begin
                    // Quotient present -> fetch remainder, and vice versa
                    op_d    = {c_qv_q, !c_sgn_q};
                    a_d     = c_a_q;
                    b_d     = c_b_q;
                    wdog_d  = '0;
                    fill_d  = 1'b1;
                    state_d = S_START;
                end
`endif
            end
            S_START: begin
                wdog_d = wdog_q + 1'b1;
                if (bus.flush) begin
                    state_d = S_DRAIN;
                end
`ifdef DIV_SEQ_PAIR_CACHE_EN
                else if (fill_q && bus.req_valid) begin
                    state_d = S_DRAIN;
                end
`endif
                else begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.div_done) begin
                    if (bus.flush) begin
                        // Divider already finished: nothing left to drain
                        state_d = S_IDLE;
                    end else begin
                        data_d  = bus.div_f;
                        state_d = S_RESP;
`ifdef DIV_SEQ_PAIR_CACHE_EN
                        c_vld_d = 1'b1;
                        c_sgn_d = !op_q[0];
                        c_a_d   = a_q;
                        c_b_d   = b_q;
                        if (op_q[1]) begin
                            c_rem_d = bus.div_f;
                            c_rv_d  = 1'b1;
                            c_qv_d  = fill_q ? c_qv_q : 1'b0;
                        end else begin
                            c_quo_d = bus.div_f;
                            c_qv_d  = 1'b1;
                            c_rv_d  = fill_q ? c_rv_q : 1'b0;
                        end
                        if (fill_q) begin
                            data_d  = data_q;
                            state_d = S_IDLE;
                        end
`endif
                    end
                end else if (bus.flush) begin
                    state_d = S_DRAIN;
                end
`ifdef DIV_SEQ_PAIR_CACHE_EN
                else if (fill_q && bus.req_valid) begin
                    state_d = S_DRAIN;
                end
`endif
                else if (wdog_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.div_done) begin
                    state_d = S_IDLE;
                end else if (wdog_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RESP: begin
                // flush wins over resp_ready; both leave for IDLE
                if (bus.flush || bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef DIV_SEQ_PAIR_CACHE_EN
        if (bus.flush) begin
            c_vld_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

`ifdef DIV_SEQ_PAIR_CACHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_vld_q <= 1'b0;
            c_sgn_q <= 1'b0;
            c_qv_q  <= 1'b0;
            c_rv_q  <= 1'b0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_quo_q <= '0;
            c_rem_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            c_vld_q <= c_vld_d;
            c_sgn_q <= c_sgn_d;
            c_qv_q  <= c_qv_d;
            c_rv_q  <= c_rv_d;
            c_a_q   <= c_a_d;
            c_b_q   <= c_b_d;
            c_quo_q <= c_quo_d;
            c_rem_q <= c_rem_d;
            fill_q  <= fill_d;
        end
    end
`endif

    // A same-cycle flush blocks acceptance and hides a pending response
    assign bus.req_ready   = (state_q == S_IDLE) && !bus.flush;
    assign bus.resp_valid  = (state_q == S_RESP) && !bus.flush;
    assign bus.resp_data   = data_q;
    assign bus.div_start   = (state_q == S_START);
    assign bus.div_op      = op_q;
    assign bus.div_a       = a_q;
    assign bus.div_b       = b_q;
    assign bus.err_timeout = err_q;
endmodule
